// File: rtl/id_ex_if.sv
// id_ex_if: decode->execute payload bundle.
//   *_i fields : driven by the ID stage, captured by id_ex.
//   *_o fields : registered copies presented to the EX stage.
//   valid_o    : 1 = real instruction, 0 = bubble.
//   bubble_cnt_o: saturating count of bubbles inserted since reset.
// Modports: master = ID/EX-side user (drives *_i, reads *_o), slave = id_ex.
interface id_ex_if;
  // ID-side payload
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [31:0] op1_jump_i;
  logic [31:0] op2_jump_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [4:0]  reg1_raddr_i;
  logic [4:0]  reg2_raddr_i;
  logic [31:0] reg1_rdata_i;
  logic [31:0] reg2_rdata_i;
  logic        op1_src_reg_i;
  logic        op2_src_reg_i;

  // EX-side payload
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] op1_jump_o;
  logic [31:0] op2_jump_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [4:0]  reg1_raddr_o;
  logic [4:0]  reg2_raddr_o;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic        op1_src_reg_o;
  logic        op2_src_reg_o;
  logic        valid_o;
  logic [15:0] bubble_cnt_o;

  modport master (
    output inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
           reg_we_i, reg_waddr_i, reg1_raddr_i, reg2_raddr_i,
           reg1_rdata_i, reg2_rdata_i, op1_src_reg_i, op2_src_reg_i,
    input  inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o,
           reg_we_o, reg_waddr_o, reg1_raddr_o, reg2_raddr_o,
           reg1_rdata_o, reg2_rdata_o, op1_src_reg_o, op2_src_reg_o,
           valid_o, bubble_cnt_o
  );

  modport slave (
    input  inst_i, inst_addr_i, op1_i, op2_i, op1_jump_i, op2_jump_i,
           reg_we_i, reg_waddr_i, reg1_raddr_i, reg2_raddr_i,
           reg1_rdata_i, reg2_rdata_i, op1_src_reg_i, op2_src_reg_i,
    output inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o,
           reg_we_o, reg_waddr_o, reg1_raddr_o, reg2_raddr_o,
           reg1_rdata_o, reg2_rdata_o, op1_src_reg_o, op2_src_reg_o,
           valid_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex.sv
// id_ex: decode->execute pipeline register.
//   Captures the ID payload and presents it to EX one cycle later. Stalls on
//   hold requests, inserts FLUSH_CYCLES NOP bubbles after a taken jump and
//   keeps a saturating count of inserted bubbles.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   hold_flag_i  pipeline hold code from ctrl; >=3 stalls this stage
//   jump_flag_i  taken jump/branch from EX
//   wb_we_i/wb_waddr_i/wb_wdata_i  EX write-back (used only for forwarding)
//   bus          id_ex_if.slave, ID payload in / EX payload out
// Optional feature macro: ID_EX_FWD_EN -- when defined, an EX write-back that
//   targets a captured rs1/rs2 replaces the stale register data (and the
//   operand sourced from it) on loading and hold edges.
module id_ex #(
  parameter int unsigned FLUSH_CYCLES = 1,            // 1..7
  parameter logic [31:0] INST_NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  hold_flag_i,
  input  logic        jump_flag_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  id_ex_if.slave      bus
);

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned CW       = 3;
  localparam int unsigned BCW      = 16;
  localparam logic [2:0]  HOLD_ID  = 3'd3;
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [BCW-1:0] BCNT_MAX   = {BCW{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Everything that travels from ID to EX, plus the valid marker.
  typedef struct packed {
    logic [DW-1:0] inst;
    logic [DW-1:0] inst_addr;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] op1_jump;
    logic [DW-1:0] op2_jump;
    logic          reg_we;
    logic [AW-1:0] reg_waddr;
    logic [AW-1:0] reg1_raddr;
    logic [AW-1:0] reg2_raddr;
    logic [DW-1:0] reg1_rdata;
    logic [DW-1:0] reg2_rdata;
    logic          op1_src_reg;
    logic          op2_src_reg;
    logic          valid;
  } pipe_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  pipe_t           pipe_q, pipe_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            load_bubble;
  logic            hold;
  pipe_t           load_val;
  pipe_t           held_val;

  // Bubble entry: NOP with no write-back and all other fields cleared.
  function automatic pipe_t bubble_entry();
    pipe_t b;
    b      = '0;
    b.inst = INST_NOP;
    return b;
  endfunction

`ifdef ID_EX_FWD_EN
  // Replace stale rs1/rs2 data when the EX write-back targets it (x0 excluded).
  function automatic pipe_t fwd_patch(input pipe_t p, input logic we,
                                      input logic [AW-1:0] waddr,
                                      input logic [DW-1:0] wdata);
    pipe_t r;
    r = p;
    if (we && (waddr != '0) && (waddr == p.reg1_raddr)) begin
      r.reg1_rdata = wdata;
      if (p.op1_src_reg) r.op1 = wdata;
    end
    if (we && (waddr != '0) && (waddr == p.reg2_raddr)) begin
      r.reg2_rdata = wdata;
      if (p.op2_src_reg) r.op2 = wdata;
    end
    return r;
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we_i, wb_waddr_i, wb_wdata_i};
`endif

  assign hold = (hold_flag_i >= HOLD_ID);

  // Fresh entry built from the ID-side inputs.
  always_comb begin
    load_val             = '0;
    load_val.inst        = bus.inst_i;
    load_val.inst_addr   = bus.inst_addr_i;
    load_val.op1         = bus.op1_i;
    load_val.op2         = bus.op2_i;
    load_val.op1_jump    = bus.op1_jump_i;
    load_val.op2_jump    = bus.op2_jump_i;
    load_val.reg_we      = bus.reg_we_i;
    load_val.reg_waddr   = bus.reg_waddr_i;
    load_val.reg1_raddr  = bus.reg1_raddr_i;
    load_val.reg2_raddr  = bus.reg2_raddr_i;
    load_val.reg1_rdata  = bus.reg1_rdata_i;
    load_val.reg2_rdata  = bus.reg2_rdata_i;
    load_val.op1_src_reg = bus.op1_src_reg_i;
    load_val.op2_src_reg = bus.op2_src_reg_i;
    load_val.valid       = 1'b1;
`ifdef ID_EX_FWD_EN
    load_val = fwd_patch(load_val, wb_we_i, wb_waddr_i, wb_wdata_i);
`endif
  end

  // Entry kept across a hold edge; a held bubble is never patched.
  always_comb begin
    held_val = pipe_q;
`ifdef ID_EX_FWD_EN
    if (pipe_q.valid) held_val = fwd_patch(pipe_q, wb_we_i, wb_waddr_i, wb_wdata_i);
`endif
  end

  // Next-state and next-payload: jump > hold > flush countdown > load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pipe_d      = pipe_q;
    load_bubble = 1'b0;

    if (jump_flag_i) begin
      pipe_d      = bubble_entry();
      load_bubble = 1'b1;
      cnt_d       = CNT_RELOAD;
      state_d     = (CNT_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end else if (hold) begin
      pipe_d = held_val;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          pipe_d      = bubble_entry();
          load_bubble = 1'b1;
          cnt_d       = cnt_q - CW'(1);
          state_d     = (cnt_q == CW'(1)) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          pipe_d = load_val;
        end
      endcase
    end

    bcnt_d = bcnt_q;
    if (load_bubble && (bcnt_q != BCNT_MAX)) bcnt_d = bcnt_q + BCW'(1);
  end

  // State, countdown, payload and bubble counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pipe_q  <= bubble_entry();
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.inst_o        = pipe_q.inst;
  assign bus.inst_addr_o   = pipe_q.inst_addr;
  assign bus.op1_o         = pipe_q.op1;
  assign bus.op2_o         = pipe_q.op2;
  assign bus.op1_jump_o    = pipe_q.op1_jump;
  assign bus.op2_jump_o    = pipe_q.op2_jump;
  assign bus.reg_we_o      = pipe_q.reg_we;
  assign bus.reg_waddr_o   = pipe_q.reg_waddr;
  assign bus.reg1_raddr_o  = pipe_q.reg1_raddr;
  assign bus.reg2_raddr_o  = pipe_q.reg2_raddr;
  assign bus.reg1_rdata_o  = pipe_q.reg1_rdata;
  assign bus.reg2_rdata_o  = pipe_q.reg2_rdata;
  assign bus.op1_src_reg_o = pipe_q.op1_src_reg;
  assign bus.op2_src_reg_o = pipe_q.op2_src_reg;
  assign bus.valid_o       = pipe_q.valid;
  assign bus.bubble_cnt_o  = bcnt_q;

endmodule

// File: tb/tb_id_ex.sv
// Directed bench for id_ex built with FLUSH_CYCLES=2.
module tb_id_ex;

  logic        clk;
  logic        rst;
  logic [2:0]  hold_flag_i;
  logic        jump_flag_i;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;

  int n_assert;
  int n_fail;

  id_ex_if bus_if ();

  id_ex #(.FLUSH_CYCLES(2), .INST_NOP(32'h0000_0013)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold_flag_i (hold_flag_i),
    .jump_flag_i (jump_flag_i),
    .wb_we_i     (wb_we_i),
    .wb_waddr_i  (wb_waddr_i),
    .wb_wdata_i  (wb_wdata_i),
    .bus         (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] fwd_exp;
  logic [31:0] hold_fwd_exp;

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef ID_EX_FWD_EN
    fwd_exp      = 32'd9;
    hold_fwd_exp = 32'h99;
`else
    fwd_exp      = 32'd7;
    hold_fwd_exp = 32'd7;
`endif
    rst = 1'b1; hold_flag_i = 3'd0; jump_flag_i = 1'b0;
    wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0;
    bus_if.inst_i = 32'h0; bus_if.inst_addr_i = 32'h0;
    bus_if.op1_i = 32'h0; bus_if.op2_i = 32'h0;
    bus_if.op1_jump_i = 32'h0; bus_if.op2_jump_i = 32'h0;
    bus_if.reg_we_i = 1'b0; bus_if.reg_waddr_i = 5'd0;
    bus_if.reg1_raddr_i = 5'd0; bus_if.reg2_raddr_i = 5'd0;
    bus_if.reg1_rdata_i = 32'h0; bus_if.reg2_rdata_i = 32'h0;
    bus_if.op1_src_reg_i = 1'b0; bus_if.op2_src_reg_i = 1'b0;

    // Reset
    step(); step();
    rst = 1'b0;
    check("rst_inst",   bus_if.inst_o, 32'h13);
    check("rst_valid",  32'(bus_if.valid_o), 32'd0);
    check("rst_reg_we", 32'(bus_if.reg_we_o), 32'd0);
    check("rst_bcnt",   32'(bus_if.bubble_cnt_o), 32'd0);
    check("rst_op1",    bus_if.op1_o, 32'd0);

    // Load
    bus_if.inst_i = 32'h0050_0093; bus_if.op1_i = 32'd5;
    bus_if.reg_we_i = 1'b1; bus_if.reg_waddr_i = 5'd1;
    bus_if.inst_addr_i = 32'h100; bus_if.op2_jump_i = 32'h44;
    step();
    check("ld_inst",   bus_if.inst_o, 32'h0050_0093);
    check("ld_op1",    bus_if.op1_o, 32'd5);
    check("ld_reg_we", 32'(bus_if.reg_we_o), 32'd1);
    check("ld_waddr",  32'(bus_if.reg_waddr_o), 32'd1);
    check("ld_valid",  32'(bus_if.valid_o), 32'd1);
    check("ld_iaddr",  bus_if.inst_addr_o, 32'h100);
    check("ld_op2j",   bus_if.op2_jump_o, 32'h44);

    // Hold for three edges while inputs change
    hold_flag_i = 3'd3;
    bus_if.inst_i = 32'h00a0_0113; bus_if.op1_i = 32'd10; bus_if.reg_waddr_i = 5'd2;
    step(); step();
    hold_flag_i = 3'd5;
    step();
    check("hold_inst",  bus_if.inst_o, 32'h0050_0093);
    check("hold_op1",   bus_if.op1_o, 32'd5);
    check("hold_waddr", 32'(bus_if.reg_waddr_o), 32'd1);
    hold_flag_i = 3'd2;
    step();
    check("unhold_inst", bus_if.inst_o, 32'h00a0_0113);
    check("unhold_op1",  bus_if.op1_o, 32'd10);

    // Jump with FLUSH_CYCLES=2: two bubbles then resume
    jump_flag_i = 1'b1;
    step();
    jump_flag_i = 1'b0;
    check("fl1_valid",  32'(bus_if.valid_o), 32'd0);
    check("fl1_inst",   bus_if.inst_o, 32'h13);
    check("fl1_reg_we", 32'(bus_if.reg_we_o), 32'd0);
    check("fl1_op1",    bus_if.op1_o, 32'd0);
    check("fl1_bcnt",   32'(bus_if.bubble_cnt_o), 32'd1);
    step();
    check("fl2_valid",  32'(bus_if.valid_o), 32'd0);
    check("fl2_inst",   bus_if.inst_o, 32'h13);
    check("fl2_bcnt",   32'(bus_if.bubble_cnt_o), 32'd2);
    step();
    check("fl_resume_inst",  bus_if.inst_o, 32'h00a0_0113);
    check("fl_resume_valid", 32'(bus_if.valid_o), 32'd1);
    check("fl_resume_bcnt",  32'(bus_if.bubble_cnt_o), 32'd2);

    // Jump during hold: bubble loads, then frozen while held
    hold_flag_i = 3'd3; jump_flag_i = 1'b1;
    step();
    jump_flag_i = 1'b0;
    check("jh_valid", 32'(bus_if.valid_o), 32'd0);
    check("jh_bcnt",  32'(bus_if.bubble_cnt_o), 32'd3);
    step(); step();
    check("jh_held_valid", 32'(bus_if.valid_o), 32'd0);
    check("jh_held_inst",  bus_if.inst_o, 32'h13);
    check("jh_held_bcnt",  32'(bus_if.bubble_cnt_o), 32'd3);
    hold_flag_i = 3'd0;
    step();
    check("jh_cd_valid", 32'(bus_if.valid_o), 32'd0);
    check("jh_cd_bcnt",  32'(bus_if.bubble_cnt_o), 32'd4);
    step();
    check("jh_ld_valid", 32'(bus_if.valid_o), 32'd1);

    // Saturation: drive jump continuously to reach FFFE, then 3 more
    jump_flag_i = 1'b1;
    repeat (65530) @(posedge clk);
    #1;
    check("sat_fffe", 32'(bus_if.bubble_cnt_o), 32'h0000_FFFE);
    step(); step(); step();
    check("sat_ffff", 32'(bus_if.bubble_cnt_o), 32'h0000_FFFF);
    jump_flag_i = 1'b0;
    step(); step();
    check("sat_hold_val",  32'(bus_if.bubble_cnt_o), 32'h0000_FFFF);
    check("sat_ld_valid",  32'(bus_if.valid_o), 32'd1);

    // Write-back forwarding on rs1; rs2 not targeted
    bus_if.reg1_raddr_i = 5'd3; bus_if.reg1_rdata_i = 32'd7;
    bus_if.op1_src_reg_i = 1'b1; bus_if.op1_i = 32'd7;
    bus_if.reg2_raddr_i = 5'd4; bus_if.reg2_rdata_i = 32'h44;
    bus_if.op2_src_reg_i = 1'b0; bus_if.op2_i = 32'h55;
    wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'd9;
    step();
    check("fwd_rdata1", bus_if.reg1_rdata_o, fwd_exp);
    check("fwd_op1",    bus_if.op1_o, fwd_exp);
    check("fwd_rdata2", bus_if.reg2_rdata_o, 32'h44);
    check("fwd_op2",    bus_if.op2_o, 32'h55);

    // x0 is never forwarded
    bus_if.reg1_raddr_i = 5'd0; wb_waddr_i = 5'd0;
    step();
    check("x0_rdata1", bus_if.reg1_rdata_o, 32'd7);
    check("x0_op1",    bus_if.op1_o, 32'd7);

    // Held entry patched by a later write-back to its stored rs1
    bus_if.reg1_raddr_i = 5'd3; wb_we_i = 1'b0;
    step();
    check("hp_pre_rdata1", bus_if.reg1_rdata_o, 32'd7);
    hold_flag_i = 3'd3; wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'h99;
    step();
    check("hp_rdata1", bus_if.reg1_rdata_o, hold_fwd_exp);
    check("hp_op1",    bus_if.op1_o, hold_fwd_exp);
    hold_flag_i = 3'd0; wb_we_i = 1'b0;

    // Reset mid-run clears counter and payload
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_bcnt",  32'(bus_if.bubble_cnt_o), 32'd0);
    check("rst2_inst",  bus_if.inst_o, 32'h13);
    check("rst2_valid", 32'(bus_if.valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
